// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32 data-memory responder: funct3 codes, FSM
// states, access sizes and latency bounds.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } dmem_size_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Unlisted codes fall back to a word access.
  function automatic dmem_size_e f3_size(input logic legal, input logic [2:0] f3);
    if (!legal) begin
      return SZ_WORD;
    end
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling: store byte enables and lane replication, load
// lane select with sign/zero extension, and the optional alignment/illegal
// check enabled by DMEM_ALIGN_CHECK_EN.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic       legal;
  logic       sext;
  dmem_size_e size;
  logic [1:0] off;
  logic [31:0] shifted;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic s);
    return {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic s);
    return {{16{s & h[15]}}, h};
  endfunction

  assign legal = f3_legal(we_i, funct3_i);
  assign size  = f3_size(legal, funct3_i);
  assign sext  = ~funct3_i[2];

  // Misaligned low address bits are dropped so the access stays inside one word.
  always_comb begin
    off = 2'b00;
    case (size)
      SZ_BYTE: off = addr_lo_i;
      SZ_HALF: off = {addr_lo_i[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic misal;
  assign misal = ((size == SZ_HALF) && addr_lo_i[0]) ||
                 ((size == SZ_WORD) && (addr_lo_i != 2'b00));
  assign err_o = ~legal | misal;
`else
  assign err_o = 1'b0;
`endif

  assign shifted = rword_i >> {off, 3'b000};

  always_comb begin
    be_o    = 4'b0000;
    wlane_o = wdata_i;
    rdata_o = rword_i;
    case (size)
      SZ_BYTE: begin
        be_o    = 4'(4'b0001 << off);
        wlane_o = {4{wdata_i[7:0]}};
        rdata_o = ext_byte(shifted[7:0], sext);
      end
      SZ_HALF: begin
        be_o    = 4'(4'b0011 << off);
        wlane_o = {2{wdata_i[15:0]}};
        rdata_o = ext_half(shifted[15:0], sext);
      end
      default: begin
        be_o    = 4'b1111;
        wlane_o = wdata_i;
        rdata_o = rword_i;
      end
    endcase
    if (err_o) begin
      be_o    = 4'b0000;
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port RV32 data-memory responder with valid/ready request and response
// channels and a fixed LATENCY. Optional alignment checking: DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LAT_EFF = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                           (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

  logic [31:0]          mem_q [DEPTH];
  dmem_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic [31:0]          rsp_rdata_q;

  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]          rword;
  logic [31:0]          wword_d;
  logic [31:0]          wlane;
  logic [31:0]          ld_data;
  logic [3:0]           be;
  logic                 acc_err;
  logic                 accept;
  logic                 unused_addr;

  assign widx        = req_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
  assign rword       = mem_q[widx];
  assign accept      = req_valid & req_ready_q;

  dmem_lane_align u_align (
    .we_i      (req_we),
    .funct3_i  (req_funct3),
    .addr_lo_i (req_addr[1:0]),
    .wdata_i   (req_wdata),
    .rword_i   (rword),
    .be_o      (be),
    .wlane_o   (wlane),
    .rdata_o   (ld_data),
    .err_o     (acc_err)
  );

  always_comb begin
    wword_d = rword;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        wword_d[8*i +: 8] = wlane[8*i +: 8];
      end
    end
  end

  // Stores commit on the acceptance edge; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (accept && req_we) begin
      mem_q[widx] <= wword_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            rsp_rdata_q <= req_we ? 32'h0 : ld_data;
            rsp_err_q   <= acc_err;
            req_ready_q <= 1'b0;
            if (LAT_EFF == 1) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              cnt_q   <= CNT_W'(LAT_EFF - 1);
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=1, one at LATENCY=3,
// with a response scoreboard and stability/throughput checks.
module tb_dmem_responder;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int checks = 0;
  int errors = 0;
  logic [32:0] sb_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int d, input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk(32'(req_ready[d]), 32'd1, {tag, "_ready"});
  endtask

  task automatic xact(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int hold, input string tag);
    int lat;
    logic [32:0] e;
    string t;
    lat = (d == 0) ? 1 : 3;
    sb_q.push_back({exp_err, exp_rd});
    tag_q.push_back(tag);
    wait_ready(d, tag);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_we[d]    = 1'b0;
    req_wdata[d] = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk(32'(rsp_valid[d]), (k == lat) ? 32'd1 : 32'd0, {tag, "_valid_lat"});
      chk(32'(req_ready[d]), 32'd0, {tag, "_busy"});
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      chk(rsp_rdata[d], e[31:0], {t, "_rdata"});
      chk(32'(rsp_err[d]), 32'(e[32]), {t, "_err"});
      if (h > 0) begin
        chk(32'(rsp_valid[d]), 32'd1, {t, "_hold_valid"});
        chk(32'(req_ready[d]), 32'd0, {t, "_hold_busy"});
      end
      if (h < hold) @(negedge clk);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk(32'(req_ready[d]), 32'd1, {t, "_ready_after"});
    chk(32'(rsp_valid[d]), 32'd0, {t, "_valid_drop"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'b000;
      req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(32'(req_ready[i]), 32'd1, "rst_req_ready");
      chk(32'(rsp_valid[i]), 32'd0, "rst_rsp_valid");
      chk(rsp_rdata[i], 32'd0, "rst_rsp_rdata");
      chk(32'(rsp_err[i]), 32'd0, "rst_rsp_err");
    end

    // LATENCY=1 instance: word, byte and half accesses.
    xact(0, 1'b1, F3_SW,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 0, "sw_100");
    xact(0, 1'b0, F3_LW,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 0, "lw_100");
    xact(0, 1'b0, F3_LB,  32'h103, 32'h0,        32'hFFFFFFDE, 1'b0, 0, "lb_103");
    xact(0, 1'b0, F3_LBU, 32'h103, 32'h0,        32'h000000DE, 1'b0, 0, "lbu_103");
    xact(0, 1'b0, F3_LH,  32'h102, 32'h0,        32'hFFFFDEAD, 1'b0, 0, "lh_102");
    xact(0, 1'b0, F3_LHU, 32'h100, 32'h0,        32'h0000BEEF, 1'b0, 0, "lhu_100");
    xact(0, 1'b1, F3_SB,  32'h101, 32'hAAAAAA55, 32'h0,        1'b0, 0, "sb_101");
    xact(0, 1'b0, F3_LW,  32'h100, 32'h0,        32'hDEAD55EF, 1'b0, 0, "lw_after_sb");
    xact(0, 1'b0, F3_LB,  32'h101, 32'h0,        32'h00000055, 1'b0, 0, "lb_101");
    xact(0, 1'b0, F3_LB,  32'h100, 32'h0,        32'hFFFFFFEF, 1'b0, 0, "lb_100");

`ifdef DMEM_ALIGN_CHECK_EN
    xact(0, 1'b0, F3_LW,  32'h102, 32'h0,        32'h0,        1'b1, 0, "lw_mis");
    xact(0, 1'b1, F3_SW,  32'h102, 32'hCAFEF00D, 32'h0,        1'b1, 0, "sw_mis");
    xact(0, 1'b0, F3_LH,  32'h101, 32'h0,        32'h0,        1'b1, 0, "lh_mis");
    xact(0, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 0, "ld_bad_f3");
    xact(0, 1'b1, 3'b100, 32'h100, 32'h11111111, 32'h0,        1'b1, 0, "st_bad_f3");
    xact(0, 1'b0, F3_LW,  32'h100, 32'h0,        32'hDEAD55EF, 1'b0, 0, "lw_unchanged");
`else
    xact(0, 1'b0, F3_LW,  32'h102, 32'h0,        32'hDEAD55EF, 1'b0, 0, "lw_mis_align");
    xact(0, 1'b0, F3_LH,  32'h101, 32'h0,        32'h000055EF, 1'b0, 0, "lh_mis_align");
    xact(0, 1'b0, 3'b011, 32'h100, 32'h0,        32'hDEAD55EF, 1'b0, 0, "ld_f3_as_word");
`endif

    // Mixed byte/half stores assembling one word.
    xact(0, 1'b1, F3_SH,  32'h306, 32'h12348001, 32'h0,        1'b0, 0, "sh_306");
    xact(0, 1'b1, F3_SB,  32'h304, 32'h0000007F, 32'h0,        1'b0, 0, "sb_304");
    xact(0, 1'b1, F3_SB,  32'h305, 32'h00000080, 32'h0,        1'b0, 0, "sb_305");
    xact(0, 1'b0, F3_LW,  32'h304, 32'h0,        32'h8001807F, 1'b0, 0, "lw_304");
    xact(0, 1'b0, F3_LH,  32'h306, 32'h0,        32'hFFFF8001, 1'b0, 0, "lh_306");
    xact(0, 1'b0, F3_LHU, 32'h304, 32'h0,        32'h0000807F, 1'b0, 0, "lhu_304");
    xact(0, 1'b0, F3_LH,  32'h304, 32'h0,        32'hFFFF807F, 1'b0, 0, "lh_304");
    xact(0, 1'b0, F3_LBU, 32'h305, 32'h0,        32'h00000080, 1'b0, 0, "lbu_305");

    // Upper address bits alias modulo the depth.
    xact(0, 1'b1, F3_SW,  32'h00001104, 32'h0BADC0DE, 32'h0,   1'b0, 0, "sw_alias");
    xact(0, 1'b0, F3_LW,  32'h104, 32'h0,        32'h0BADC0DE, 1'b0, 0, "lw_alias");

    // LATENCY=3 instance with response back-pressure.
    xact(1, 1'b1, F3_SW,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 0, "l3_sw_100");
    xact(1, 1'b0, F3_LW,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4, "l3_lw_hold");
    xact(1, 1'b0, F3_LBU, 32'h102, 32'h0,        32'h000000AD, 1'b0, 2, "l3_lbu_hold");

    // Reset while waiting: response dropped, store kept.
    wait_ready(1, "l3_rst_sw");
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = F3_SW;
    req_addr[1] = 32'h200; req_wdata[1] = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0; req_we[1] = 1'b0;
    @(negedge clk);
    chk(32'(rsp_valid[1]), 32'd0, "l3_rst_pre_valid");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk(32'(rsp_valid[1]), 32'd0, "l3_rst_no_valid");
      chk(32'(req_ready[1]), 32'd1, "l3_rst_ready");
    end
    xact(1, 1'b0, F3_LW,  32'h200, 32'h0,        32'h12345678, 1'b0, 0, "l3_lw_200");
    xact(0, 1'b0, F3_LW,  32'h100, 32'h0,        32'hDEAD55EF, 1'b0, 0, "l1_mem_kept");

    chk(32'(sb_q.size()), 32'd0, "sb_empty");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Single-port data-memory responder that sits on the load/store side of `core`, answering the core's memory requests. Accepts one request at a time over a valid/ready handshake and commits stores with RV32 byte/half/word lane handling. Returns load data with sign or zero extension after a configurable fixed latency. Serves as the target end of the core's data-memory interface in both simulation benches and synthesis.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 1: cycles from request acceptance to `rsp_valid`; legal range 1..4.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 size/sign code from the load/store instruction.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (rs2 value).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  core accepts the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores.
- `rsp_err`  out  1  misaligned or illegal access (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, the request is accepted. If LATENCY==1, go to RESP; otherwise load the counter with LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter; go to RESP when the counter reaches 1.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- `req_ready`=1 only in IDLE. Only one request is outstanding.
- Stores write the array on the acceptance edge. Load data is sampled from the array on the acceptance edge and held in a response register.
- Word index = `req_addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses alias modulo the depth.
- Loads:
  - funct3 000 LB: sign-extend the byte at `addr[1:0]`.
  - 100 LBU: zero-extend that byte.
  - 001 LH: sign-extend the half at `addr[1]`.
  - 101 LHU: zero-extend that half.
  - 010 LW: full word.
- Stores:
  - 000 SB: `wdata[7:0]` to the addressed byte lane.
  - 001 SH: `wdata[15:0]` to the addressed half.
  - 010 SW: full word.
  - Unaddressed lanes are unchanged.
- `rsp_rdata`, `rsp_err` and `rsp_valid` are stable while `rsp_valid`=1 and `rsp_ready`=0.

## Timing
- Reset values:
  - FSM in IDLE, `req_ready`=1, `rsp_valid`=0.
  - `rsp_rdata`=0, `rsp_err`=0, counter=0.
  - Memory contents are not reset.
- Request accepted at edge N → `rsp_valid` first high in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles later.
- Response handshake at edge M → `req_ready`=1 in the cycle after M. Peak throughput is one request per LATENCY+1 cycles.
- `req_valid` while not ready: ignored. The core must hold the request.
- Reset mid-operation (WAIT or RESP): the pending response is dropped. A store already committed at acceptance remains in memory.
- Store to a word followed by a load of the same word: the load returns the new data, because the writes occurred on earlier edges.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - These accesses raise `rsp_err`=1, perform no write and return `rsp_rdata`=0:
    - half access with `addr[0]`=1;
    - word access with `addr[1:0]`≠0;
    - funct3 ∉ {000,001,010,100,101} for loads;
    - funct3 ∉ {000,001,010} for stores.
  - Latency is unchanged.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - `rsp_err` is tied 0.
  - Misaligned addresses are aligned down: `addr[0]` is cleared for half accesses, `addr[1:0]` for word accesses.
  - Unlisted funct3 values are treated as a word access.

## Structure
- Shared package `riscv_mem_pkg`: funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW), FSM state encoding, LATENCY bounds.
- Sub-module `dmem_lane_align` (combinational):
  - store path: byte-enable generation and write-data lane replication;
  - load path: lane select plus sign/zero extension;
  - alignment/illegal check.
- The top level holds the FSM, latency counter, response registers and memory array.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x100, then LW 0x100 with LATENCY=1 → `rsp_valid` one cycle after acceptance, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- After that, LB 0x103 → 0xFFFFFFDE; LBU 0x103 → 0x000000DE; LH 0x102 → 0xFFFFDEAD; LHU 0x100 → 0x0000BEEF.
- SB 0x55 to 0x101 over 0xDEADBEEF, then LW 0x100 → 0xDEAD55EF.
- LATENCY=3 with `rsp_ready` held 0 for 4 cycles after `rsp_valid` → response stable throughout, `req_ready`=0 until the cycle after the handshake.
- With the macro: LW 0x102 → `rsp_err`=1, `rsp_rdata`=0, and a following SW 0x102 leaves memory unchanged. Without the macro: LW 0x102 returns the word at 0x100.
- Reset asserted in WAIT after an accepted SW 0x12345678 to 0x200 → `rsp_valid` never asserts, `req_ready`=1 after reset, and a subsequent LW 0x200 → 0x12345678.
